// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline register for N write-back lanes plus HI/LO, with a one-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 transfer per cycle with out_ready high.
// Backpressure: in_ready is a registered decode (~skid_valid), so a stalled WB stage never drops an instruction.
//
// Optional build macro: MEM_WB_STALL_CNT_EN adds a 32-bit saturating stall counter output (stall_cnt).
//
// Ports:
//   clk, rst                  pipeline clock; asynchronous active-low reset
//   in_valid / in_ready       MEM-side handshake
//   in_wd/in_wreg/in_wdata    per-lane destination, write enable, write data (lane 0 in LSBs)
//   in_whilo/in_hi/in_lo      HI/LO write enable and values
//   flush                     synchronous kill of both held entries
//   out_valid / out_ready     WB-side handshake
//   out_*                     payload to WB; out_wreg and out_whilo are gated by out_valid
//   stall_cnt                 (MEM_WB_STALL_CNT_EN only) cycles with out_valid & ~out_ready

module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int LANES  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*ADDR_W-1:0]   in_wd,
   input  logic [LANES-1:0]          in_wreg,
   input  logic [LANES*DATA_W-1:0]   in_wdata,
   input  logic                      in_whilo,
   input  logic [DATA_W-1:0]         in_hi,
   input  logic [DATA_W-1:0]         in_lo,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*ADDR_W-1:0]   out_wd,
   output logic [LANES-1:0]          out_wreg,
   output logic [LANES*DATA_W-1:0]   out_wdata,
   output logic                      out_whilo,
   output logic [DATA_W-1:0]         out_hi,
   output logic [DATA_W-1:0]         out_lo
`ifdef MEM_WB_STALL_CNT_EN
   ,
   output logic [31:0]               stall_cnt
`endif
);

   // One stored instruction: every field that travels from MEM to WB.
   typedef struct packed {
      logic [LANES*ADDR_W-1:0] wd;
      logic [LANES-1:0]        wreg;
      logic [LANES*DATA_W-1:0] wdata;
      logic                    whilo;
      logic [DATA_W-1:0]       hi;
      logic [DATA_W-1:0]       lo;
   } entry_t;

   entry_t in_ent;
   entry_t main_q;
   entry_t skid_q;
   logic   main_vld;
   logic   skid_vld;

   logic   main_vld_d;
   logic   skid_vld_d;
   logic   load_main_in;
   logic   load_main_skid;
   logic   load_skid;
   logic   accept;
   logic   drain;

   assign in_ent.wd    = in_wd;
   assign in_ent.wreg  = in_wreg;
   assign in_ent.wdata = in_wdata;
   assign in_ent.whilo = in_whilo;
   assign in_ent.hi    = in_hi;
   assign in_ent.lo    = in_lo;

   // Depends only on reset and stored state, never on out_ready, so the
   // MEM stage sees no combinational path back from WB.
   assign in_ready = rst & ~skid_vld;
   assign accept   = in_valid & in_ready;
   assign drain    = main_vld & out_ready;

   // Next-state decode for the two-entry buffer. Skid always empties into
   // main before new input is taken, which keeps ordering strictly FIFO.
   always_comb begin
      main_vld_d     = main_vld;
      skid_vld_d     = skid_vld;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         // Flush beats drain and accept; an input accepted this cycle is lost.
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld || drain) begin
         if (skid_vld) begin
            load_main_skid = 1'b1;
            main_vld_d     = 1'b1;
            skid_vld_d     = 1'b0;
         end else if (accept) begin
            load_main_in = 1'b1;
            main_vld_d   = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         load_skid  = 1'b1;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else begin
         main_vld <= main_vld_d;
         skid_vld <= skid_vld_d;
      end
   end

   // Payload registers are enabled only when their entry is written, so idle
   // or stalled cycles do not toggle the wide data path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '0;
      end else if (load_main_skid) begin
         main_q <= skid_q;
      end else if (load_main_in) begin
         main_q <= in_ent;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_q <= '0;
      end else if (load_skid) begin
         skid_q <= in_ent;
      end
   end

   // Write enables are masked by valid so a bubble or a flushed entry can
   // never write the register file or HI/LO, even if stale payload remains.
   assign out_valid = main_vld;
   assign out_wd    = main_q.wd;
   assign out_wreg  = main_q.wreg & {LANES{main_vld}};
   assign out_wdata = main_q.wdata;
   assign out_whilo = main_q.whilo & main_vld;
   assign out_hi    = main_q.hi;
   assign out_lo    = main_q.lo;

`ifdef MEM_WB_STALL_CNT_EN
   // Saturating count of WB stall cycles; survives flush, cleared by reset only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 32'd0;
      end else if (main_vld && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised successor to the single-lane MEM/WB latch.
- Carries N write-back lanes plus the HI/LO write from the MEM stage to the WB stage.
- Adds a valid/ready handshake with a one-entry skid buffer, so backpressure from WB never drops an instruction.
- Adds a synchronous flush driven by the pipeline controller.

Parameters:
- DATA_W, 32, width of each register write value and of HI/LO.
- ADDR_W, 5, register-file address width.
- LANES, 1, number of register write-back lanes (1..4); fields are packed with lane 0 in the LSBs.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents a valid instruction.
- in_ready  out  1  block can accept this cycle.
- in_wd  in  LANES*ADDR_W  destination register per lane.
- in_wreg  in  LANES  write enable per lane.
- in_wdata  in  LANES*DATA_W  write data per lane.
- in_whilo  in  1  HI/LO write enable.
- in_hi  in  DATA_W  HI value.
- in_lo  in  DATA_W  LO value.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  WB stage payload valid.
- out_ready  in  1  WB stage consumes this cycle.
- out_wd  out  LANES*ADDR_W  to WB.
- out_wreg  out  LANES  to WB, gated by out_valid.
- out_wdata  out  LANES*DATA_W  to WB.
- out_whilo  out  1  to WB, gated by out_valid.
- out_hi  out  DATA_W  to WB.
- out_lo  out  DATA_W  to WB.

Behaviour:
- Storage is two entries:
  - main: drives the out_* ports.
  - skid: holds overflow when main is stalled.
- Each entry holds every payload field plus a valid bit.
- Reset (rst low, asynchronous):
  - both valid bits 0, all payload registers 0;
  - out_valid=0, out_wreg=0, out_whilo=0, out_wd/wdata/hi/lo=0;
  - in_ready=0 while rst is low, 1 on the first cycle after release.
- Reset asserted mid-transfer discards both entries. Nothing is replayed.
- in_ready = rst & ~skid_valid. It is a registered state decode; it has no combinational path from out_ready.
- accept = in_valid & in_ready.
- drain = out_valid & out_ready.
- Per posedge, with flush low:
  - main empty or drain, skid empty: main <= input if accept, else main_valid <= 0.
  - main empty or drain, skid full: main <= skid, skid_valid <= 0; the input cannot be accepted this cycle because in_ready=0.
  - main full, no drain, accept: skid <= input, skid_valid <= 1.
  - main full, no drain, no accept: hold.
- Flush high at posedge:
  - main_valid and skid_valid both <= 0;
  - any input accepted in the same cycle is discarded;
  - flush takes priority over drain and accept;
  - payload registers may hold stale data, but out_wreg/out_whilo read 0.
- Latency: 1 cycle from accept to out_valid when empty.
- Throughput: 1 per cycle with out_ready held high.
- Order is strict FIFO: skid never overtakes main.
- Output gating: out_wreg = stored wreg & {LANES{out_valid}}; out_whilo = stored whilo & out_valid. A bubble therefore never writes the register file or HI/LO.
- Payload is passed unmodified:
  - a lane with wd=0 and wreg=1 is forwarded as-is (WB ignores r0);
  - lanes writing the same wd are both forwarded; arbitration is the WB stage's job.
- Payload registers load only when their entry is written, to save toggling.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- Defined:
  - extra output port stall_cnt, out, 32 bits;
  - increments every cycle with out_valid & ~out_ready;
  - saturates at 32'hFFFF_FFFF;
  - cleared only by rst, not by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset/basic pass (LANES=2): release rst, drive in_valid=1, in_wd={5'd3,5'd2}, in_wreg=2'b11, in_wdata={32'hB,32'hA}, out_ready=1 -> next cycle out_valid=1, out_wd={3,2}, out_wdata={B,A}; during rst low all outputs are 0 and in_ready=0.
- Back-to-back streaming: 8 consecutive transfers with wdata=1..8 and out_ready=1 -> out_valid high 8 consecutive cycles, values 1..8 in order, in_ready constantly 1.
- Skid fill: out_ready=0, send wdata=0x10 then 0x20 -> out holds 0x10, in_ready drops to 0 after the second accept; third beat 0x30 waits; raise out_ready -> outputs 0x10, 0x20, 0x30 in order with no loss or duplicate.
- Flush with full skid: main=0x10, skid=0x20, in_valid=1 with 0x30, assert flush one cycle -> next cycle out_valid=0, out_wreg=0, out_whilo=0, in_ready=1; 0x30 never appears.
- HI/LO bubble gating: in_whilo=1, hi=0xDEAD, lo=0xBEEF, accepted then drained, in_valid=0 -> out_whilo=1 for exactly one cycle, then 0 while out_hi may still read 0xDEAD.
- (MEM_WB_STALL_CNT_EN) hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5; assert flush -> stall_cnt stays 5; assert rst -> stall_cnt=0.
